gf_2ton_koa_combiner_line: RTL

- Recombination stage of the Karatsuba (KOA) carry-less multiplier over GF(2)[x]; performs the reverse of the operand-splitting stage.
- Takes, per instance, the three half-width sub-products (low, high, middle) and merges them into the full double-width product.
- N_INSTANCES independent combiners share one valid pipeline. Sits after the sub-multipliers and before the GHASH modular reduction.

---
 rtl/gf_2ton_koa_combiner_line.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gf_2ton_koa_combiner_line.sv
// -----------------------------------------------------------------------------
// gf_2ton_koa_combiner_line
//
// Karatsuba recombination for carry-less (GF(2)[x]) multiplication. Each of the
// N_INSTANCES lanes takes the three half-width sub-products L, H, M and merges
// them into the double-width product:
//     X = M ^ L ^ H
//     P = L ^ (X << NB_DATA/2) ^ (H << NB_DATA)
// All lanes share one valid pipeline of depth CREATE_MID_REG + CREATE_OUTPUT_REG.
//
// Ports
//   i_clock          clock
//   i_reset_n        asynchronous active-low reset (data, valid and flag)
//   i_data_bus       lane k at [k*3*NB_DATA +: 3*NB_DATA] = {M, H, L}
//   i_valid          input valid, also the stage-1 load enable
//   i_clear_flag     synchronous clear of o_overflow_flag
//   o_data_bus       lane k at [k*2*NB_DATA +: 2*NB_DATA] = P
//   o_valid          o_data_bus carries a new result
//   o_overflow_flag  sticky: an accepted sub-product had its MSB set
// -----------------------------------------------------------------------------
module gf_2ton_koa_combiner_line #(
    parameter int N_INSTANCES       = 3,
    parameter int NB_DATA           = 128,
    parameter bit CREATE_MID_REG    = 1'b1,
    parameter bit CREATE_OUTPUT_REG = 1'b1
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic [3*N_INSTANCES*NB_DATA-1:0]   i_data_bus,
    input  logic                               i_valid,
    input  logic                               i_clear_flag,
    output logic [2*N_INSTANCES*NB_DATA-1:0]   o_data_bus,
    output logic                               o_valid,
    output logic                               o_overflow_flag
);

    localparam int NB_SUB = N_INSTANCES * NB_DATA;
    localparam int NB_OUT = 2 * N_INSTANCES * NB_DATA;

    // Middle term of the Karatsuba identity over GF(2).
    function automatic logic [NB_DATA-1:0] mid_term(
        input logic [NB_DATA-1:0] l,
        input logic [NB_DATA-1:0] h,
        input logic [NB_DATA-1:0] m
    );
        return m ^ l ^ h;
    endfunction

    // Overlapping XOR of the three terms into the double-width product.
    // X is only NB_DATA wide, so shifting it by NB_DATA/2 inside a
    // 2*NB_DATA container never loses bits.
    function automatic logic [2*NB_DATA-1:0] recombine(
        input logic [NB_DATA-1:0] l,
        input logic [NB_DATA-1:0] h,
        input logic [NB_DATA-1:0] x
    );
        logic [2*NB_DATA-1:0] x_ext;
        x_ext = {{NB_DATA{1'b0}}, x};
        return {{NB_DATA{1'b0}}, l} ^ (x_ext << (NB_DATA / 2)) ^ {h, {NB_DATA{1'b0}}};
    endfunction

    logic [NB_SUB-1:0] l_p0, h_p0, x_p0;
    logic              ovf_hit_p0;
    logic [NB_SUB-1:0] l_p1, h_p1, x_p1;
    logic              vld_p1;
    logic [NB_OUT-1:0] prod_p1;
    logic [NB_OUT-1:0] prod_p2;
    logic              vld_p2;
    logic              overflow_flag;

    // ---- stage 0: unpack lanes, middle XOR, MSB detection ----
    always_comb begin
        l_p0       = '0;
        h_p0       = '0;
        x_p0       = '0;
        ovf_hit_p0 = 1'b0;
        for (int k = 0; k < N_INSTANCES; k++) begin
            l_p0[k*NB_DATA +: NB_DATA] = i_data_bus[k*3*NB_DATA +: NB_DATA];
            h_p0[k*NB_DATA +: NB_DATA] = i_data_bus[k*3*NB_DATA + NB_DATA +: NB_DATA];
            x_p0[k*NB_DATA +: NB_DATA] = mid_term(i_data_bus[k*3*NB_DATA +: NB_DATA],
                                                  i_data_bus[k*3*NB_DATA + NB_DATA +: NB_DATA],
                                                  i_data_bus[k*3*NB_DATA + 2*NB_DATA +: NB_DATA]);
            ovf_hit_p0 = ovf_hit_p0
                       | i_data_bus[k*3*NB_DATA + NB_DATA - 1]
                       | i_data_bus[k*3*NB_DATA + 2*NB_DATA - 1]
                       | i_data_bus[k*3*NB_DATA + 3*NB_DATA - 1];
        end
    end

    // ---- stage 1: L, H, X held (registered or pass-through) ----
    generate
        if (CREATE_MID_REG) begin : g_mid_reg
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    l_p1   <= '0;
                    h_p1   <= '0;
                    x_p1   <= '0;
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= i_valid;
                    if (i_valid) begin
                        l_p1 <= l_p0;
                        h_p1 <= h_p0;
                        x_p1 <= x_p0;
                    end
                end
            end
        end else begin : g_mid_comb
            always_comb begin
                l_p1   = l_p0;
                h_p1   = h_p0;
                x_p1   = x_p0;
                vld_p1 = i_valid;
            end
        end
    endgenerate

    always_comb begin
        prod_p1 = '0;
        for (int k = 0; k < N_INSTANCES; k++) begin
            prod_p1[k*2*NB_DATA +: 2*NB_DATA] = recombine(l_p1[k*NB_DATA +: NB_DATA],
                                                          h_p1[k*NB_DATA +: NB_DATA],
                                                          x_p1[k*NB_DATA +: NB_DATA]);
        end
    end

    // ---- stage 2: final product (registered or pass-through) ----
    generate
        if (CREATE_OUTPUT_REG) begin : g_out_reg
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    prod_p2 <= '0;
                    vld_p2  <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        prod_p2 <= prod_p1;
                    end
                end
            end
        end else begin : g_out_comb
            always_comb begin
                prod_p2 = prod_p1;
                vld_p2  = vld_p1;
            end
        end
    endgenerate

    // Sticky overflow: a set on this edge takes precedence over a clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow_flag <= 1'b0;
        end else if (i_valid && ovf_hit_p0) begin
            overflow_flag <= 1'b1;
        end else if (i_clear_flag) begin
            overflow_flag <= 1'b0;
        end
    end

    assign o_data_bus      = prod_p2;
    assign o_valid         = vld_p2;
    assign o_overflow_flag = overflow_flag;

endmodule
